// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator datapath: FSM state
// encoding, BCD digit type and the sizing helper for the binary magnitude.
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   // Bits needed to hold any n-digit decimal magnitude: ceil(log2(10**n)).
   function automatic int clog2_pow10(input int n);
      logic [63:0] p;
      int          w;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      w = 0;
      for (int b = 0; b < 63; b++) begin
         if ((64'd1 << w) < p) begin
            w = w + 1;
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

   // True when a nibble is not a legal decimal digit.
   function automatic logic digit_gt_max(input bcd_digit_t d);
      return (d > BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Handshake and data bundle between keypad assembly logic and the
// BCD-to-binary converter.
interface bcd_to_bin_seq_if #(
   parameter int DIGITS = 3,
   parameter int OUT_W  = 8
);
   logic                  start;
   logic [4*DIGITS-1:0]   bcd_in;
   logic                  neg_n;
   logic                  busy;
   logic                  done;
   logic [OUT_W-1:0]      bin_out;
   logic                  overflow;
   logic                  err_digit;

   modport master (
      output start, bcd_in, neg_n,
      input  busy, done, bin_out, overflow, err_digit
   );

   modport slave (
      input  start, bcd_in, neg_n,
      output busy, done, bin_out, overflow, err_digit
   );
endinterface

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: after a right shift, a digit that
// received a borrowed bit from the digit above (value >= 8) is pulled back
// into decimal range by subtracting 3.
module bcd_digit_adj
   import calc_pkg::*;
(
   input  bcd_digit_t din,
   output bcd_digit_t dout
);

   // Conditional subtract-3 correction of one shifted BCD digit.
   always_comb begin
      if (din >= 4'd8) begin
         dout = din - 4'd3;
      end else begin
         dout = din;
      end
   end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential sign-magnitude BCD to two's-complement converter. The BCD
// digits sit above an empty binary field in one shift register; each SHIFT
// cycle moves one bit from the decimal part into the binary part and
// corrects the digits. After MAG_W cycles the low field holds the magnitude,
// which FINISH signs and saturates into OUT_W bits.
module bcd_to_bin_seq
   import calc_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int OUT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   bcd_to_bin_seq_if.slave   bus
);

   localparam int MAG_W = clog2_pow10(DIGITS);
   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + MAG_W;
   localparam int CNT_W = $clog2(MAG_W + 1);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MAG_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [31:0]      POS_LIM  = 32'((2 ** (OUT_W - 1)) - 1);
   localparam logic [31:0]      NEG_LIM  = 32'(2 ** (OUT_W - 1));
   localparam logic [OUT_W-1:0] SAT_POS  = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] SAT_NEG  = {1'b1, {(OUT_W-1){1'b0}}};

   state_t             state_r, state_nxt_s;
   logic [SR_W-1:0]    sr_r, sr_nxt_s;
   logic [SR_W-1:0]    shifted_s;
   logic [BCD_W-1:0]   adj_bcd_s;
   logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
   logic               neg_r, neg_nxt_s;
   logic               err_r, err_nxt_s;
   logic               busy_r, busy_nxt_s;
   logic               done_r, done_nxt_s;
   logic [OUT_W-1:0]   bin_r, bin_nxt_s;
   logic               ovf_r, ovf_nxt_s;
   logic               errd_r, errd_nxt_s;
   logic               digit_bad_s;
   logic [31:0]        mag_s;
   logic [31:0]        neg_mag_s;

   assign shifted_s = {1'b0, sr_r[SR_W-1:1]};
   assign mag_s     = 32'(sr_r[MAG_W-1:0]);
   assign neg_mag_s = 32'd0 - mag_s;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .din  (shifted_s[MAG_W + 4*g +: 4]),
            .dout (adj_bcd_s[4*g +: 4])
         );
      end
   endgenerate

   // Flag an input nibble that is not a decimal digit.
   always_comb begin
      digit_bad_s = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_gt_max(bus.bcd_in[4*i +: 4])) begin
            digit_bad_s = 1'b1;
         end else begin
            digit_bad_s = digit_bad_s;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode: illegal digits skip the shift phase entirely.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_nxt_s = digit_bad_s ? FINISH : SHIFT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_r == CNT_ONE) begin
               state_nxt_s = FINISH;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         FINISH:  state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Datapath and output next values; everything holds unless the state acts.
   always_comb begin
      sr_nxt_s   = sr_r;
      cnt_nxt_s  = cnt_r;
      neg_nxt_s  = neg_r;
      err_nxt_s  = err_r;
      busy_nxt_s = busy_r;
      done_nxt_s = 1'b0;
      bin_nxt_s  = bin_r;
      ovf_nxt_s  = ovf_r;
      errd_nxt_s = errd_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               sr_nxt_s   = {bus.bcd_in, {MAG_W{1'b0}}};
               cnt_nxt_s  = CNT_LOAD;
               neg_nxt_s  = bus.neg_n;
               err_nxt_s  = digit_bad_s;
               busy_nxt_s = 1'b1;
               ovf_nxt_s  = 1'b0;
               errd_nxt_s = 1'b0;
            end else begin
               busy_nxt_s = 1'b0;
            end
         end
         SHIFT: begin
            sr_nxt_s  = {adj_bcd_s, shifted_s[MAG_W-1:0]};
            cnt_nxt_s = cnt_r - CNT_ONE;
         end
         FINISH: begin
            done_nxt_s = 1'b1;
            busy_nxt_s = 1'b0;
            if (err_r) begin
               bin_nxt_s  = {OUT_W{1'b0}};
               errd_nxt_s = 1'b1;
               ovf_nxt_s  = 1'b0;
            end else if (neg_r) begin
               if (mag_s > POS_LIM) begin
                  bin_nxt_s = SAT_POS;
                  ovf_nxt_s = 1'b1;
               end else begin
                  bin_nxt_s = mag_s[OUT_W-1:0];
                  ovf_nxt_s = 1'b0;
               end
            end else begin
               if (mag_s > NEG_LIM) begin
                  bin_nxt_s = SAT_NEG;
                  ovf_nxt_s = 1'b1;
               end else begin
                  bin_nxt_s = neg_mag_s[OUT_W-1:0];
                  ovf_nxt_s = 1'b0;
               end
            end
         end
         default: begin
            busy_nxt_s = 1'b0;
         end
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_r   <= {SR_W{1'b0}};
         cnt_r  <= {CNT_W{1'b0}};
         neg_r  <= 1'b0;
         err_r  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         bin_r  <= {OUT_W{1'b0}};
         ovf_r  <= 1'b0;
         errd_r <= 1'b0;
      end else begin
         sr_r   <= sr_nxt_s;
         cnt_r  <= cnt_nxt_s;
         neg_r  <= neg_nxt_s;
         err_r  <= err_nxt_s;
         busy_r <= busy_nxt_s;
         done_r <= done_nxt_s;
         bin_r  <= bin_nxt_s;
         ovf_r  <= ovf_nxt_s;
         errd_r <= errd_nxt_s;
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.bin_out   = bin_r;
   assign bus.overflow  = ovf_r;
   assign bus.err_digit = errd_r;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: hand-computed conversions, saturation
// edges, digit errors, ignored start, late input changes and mid-run reset.
module tb_bcd_to_bin_seq;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_miss;
   int   cyc;
   int   done_seen;

   bcd_to_bin_seq_if #(.DIGITS(3), .OUT_W(8)) bus ();

   bcd_to_bin_seq #(.DIGITS(3), .OUT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for done, counting negedges after the one following E0.
   task automatic wait_done(output int c);
      c = 0;
      while (bus.done !== 1'b1 && c < 40) begin
         @(negedge clk);
         c++;
      end
   endtask

   // One conversion; inputs are scrambled right after acceptance.
   task automatic conv(input string tag, input logic [11:0] bcd, input logic neg,
                       input int exp_lat, input logic [7:0] exp_bin,
                       input logic exp_ovf, input logic exp_err);
      int c;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bcd_in = bcd;
      bus.neg_n  = neg;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.bcd_in = ~bcd;
      bus.neg_n  = ~neg;
      check_val({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check_val({tag, "_ovf_clr"}, 32'(bus.overflow), 32'd0);
      check_val({tag, "_err_clr"}, 32'(bus.err_digit), 32'd0);
      wait_done(c);
      check_val({tag, "_lat"}, 32'(c), 32'(exp_lat));
      check_val({tag, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
      check_val({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
      check_val({tag, "_err"}, 32'(bus.err_digit), 32'(exp_err));
      check_val({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      check_val({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      n_vec      = 0;
      n_miss     = 0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.bcd_in = 12'h000;
      bus.neg_n  = 1'b1;
      #1;
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_done", 32'(bus.done), 32'd0);
      check_val("rst_bin", 32'(bus.bin_out), 32'd0);
      check_val("rst_ovf", 32'(bus.overflow), 32'd0);
      check_val("rst_err", 32'(bus.err_digit), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      conv("p127", 12'h127, 1'b1, 11, 8'h7F, 1'b0, 1'b0);
      conv("n128", 12'h128, 1'b0, 11, 8'h80, 1'b0, 1'b0);
      conv("p128", 12'h128, 1'b1, 11, 8'h7F, 1'b1, 1'b0);
      conv("n042", 12'h042, 1'b0, 11, 8'hD6, 1'b0, 1'b0);
      conv("n000", 12'h000, 1'b0, 11, 8'h00, 1'b0, 1'b0);
      conv("p999", 12'h999, 1'b1, 11, 8'h7F, 1'b1, 1'b0);
      conv("n999", 12'h999, 1'b0, 11, 8'h80, 1'b1, 1'b0);
      conv("n100", 12'h100, 1'b0, 11, 8'h9C, 1'b0, 1'b0);
      conv("errA5", 12'h0A5, 1'b1, 1, 8'h00, 1'b0, 1'b1);
      conv("errF00", 12'hF00, 1'b0, 1, 8'h00, 1'b0, 1'b1);
      conv("p005", 12'h005, 1'b1, 11, 8'h05, 1'b0, 1'b0);

      // start while busy is ignored; the original operand completes
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bcd_in = 12'h055;
      bus.neg_n  = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.bcd_in = 12'h000;
      repeat (3) @(negedge clk);
      bus.start  = 1'b1;
      bus.bcd_in = 12'h123;
      bus.neg_n  = 1'b0;
      @(negedge clk);
      bus.start  = 1'b0;
      wait_done(cyc);
      check_val("ign_lat", 32'(cyc), 32'd7);
      check_val("ign_bin", 32'(bus.bin_out), 32'h37);
      @(negedge clk);
      check_val("ign_noqueue", 32'(bus.busy), 32'd0);

      // reset in the middle of SHIFT aborts without a done pulse
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bcd_in = 12'h999;
      bus.neg_n  = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
      check_val("mid_rst_done", 32'(bus.done), 32'd0);
      check_val("mid_rst_bin", 32'(bus.bin_out), 32'd0);
      done_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done === 1'b1) done_seen++;
      end
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (bus.done === 1'b1) done_seen++;
      end
      check_val("mid_rst_nodone", 32'(done_seen), 32'd0);
      check_val("mid_rst_idle", 32'(bus.busy), 32'd0);

      conv("p099", 12'h099, 1'b1, 11, 8'h63, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
